dmem_stage: RTL and testbench
=============================

// Module: dmem_stage
// PURPOSE
//  Data-memory stage between execute and writeback. Accepts one load/store from execute and
//  runs a req/gnt/rvalid handshake on the data-memory bus. Steers byte lanes for stores and
//  aligns and sign-extends load data. Presents load_active/next_rd/next_rd_value to writeback.
// PARAMETERS
//  XLEN        32  data width (byte lanes = XLEN/8; logic fixed to 4 lanes)
//  ADDR_W      32  byte-address width
//  REG_ADDR_W  5   destination register index width
// PORTS
//  clk            in   1           clock, all state on rising edge
//  rst            in   1           synchronous, active-high reset
//  req_valid      in   1           execute presents a memory op
//  req_ready      out  1           stage can accept (high only in IDLE)
//  req_load       in   1           op is a load
//  req_store      in   1           op is a store
//  req_funct3     in   3           RV32 size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  req_addr       in   ADDR_W      byte address
//  req_wdata      in   XLEN        store data (LSB-justified)
//  req_rd         in   REG_ADDR_W  load destination
//  mem_req        out  1           bus request, held until mem_gnt
//  mem_we         out  1           1 = write
//  mem_addr       out  ADDR_W      word-aligned address ([1:0] = 0)
//  mem_be         out  4           byte enables
//  mem_wdata      out  XLEN        lane-steered store data
//  mem_gnt        in   1           bus accepted request this cycle
//  mem_rvalid     in   1           read data valid
//  mem_rdata      in   XLEN        read word
//  load_active    out  1           one-cycle pulse: next_rd/next_rd_value hold a completed load
//  next_rd        out  REG_ADDR_W  load destination
//  next_rd_value  out  XLEN        aligned, extended load value
//  exc_valid      out  1           misaligned-access pulse (MISALIGN_TRAP_EN only; else tied 0)
//  exc_addr       out  ADDR_W      faulting address
// BEHAVIOUR
//  Reset: state=IDLE. All outputs 0, except req_ready=1.
//  FSM IDLE -> REQ -> (WAIT) -> IDLE:
//   IDLE: on req_valid & (req_load|req_store), register op, addr, wdata, rd and funct3; go to REQ.
//     If req_load and req_store are both high, the op is a load.
//   REQ:  mem_req=1 with mem_we/addr/be/wdata stable. On mem_gnt: a store goes to IDLE;
//     a load goes to WAIT.
//   WAIT: on mem_rvalid, register the extended value into next_rd_value and rd into next_rd.
//     Pulse load_active for exactly the following cycle, then go to IDLE.
//   mem_rvalid is ignored outside WAIT, including one that arrives in the same cycle as mem_gnt.
//  Latency with gnt in the first REQ cycle and rvalid one cycle later:
//   store: req_ready returns 2 cycles after accept.
//   load: load_active 3 cycles after accept.
//  next_rd/next_rd_value hold their value until the next load completes. Stores never change them.
//  Byte enables by size and addr[1:0]:
//   B = 4'b0001<<a. H = 4'b0011<<(2*a[1]). W = 4'b1111.
//   Store data is replicated across lanes (B: {4{d[7:0]}}, H: {2{d[15:0]}}).
//  Load: select the lane by addr[1:0]. Sign-extend for 000/001; zero-extend for 100/101.
//   Undefined funct3 (011, 11x) is treated as W.
//  Reset mid-operation: return to IDLE immediately and drop mem_req. A later stray rvalid is ignored.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined:
//   H with addr[0]=1, or W with addr[1:0]!=0, issues no bus request.
//   exc_valid pulses 1 cycle after accept with exc_addr = req_addr. The FSM stays in IDLE.
//  Not defined: misalignment is ignored. H uses addr[1] only; W forces lanes to 1111.
// STRUCTURE
//  dmem_pkg: state enum {IDLE,REQ,WAIT}, funct3 localparams (F3_B/H/W/BU/HU), be/extend helpers.
//  dmem_align: combinational sub-module for byte-enable generation, store-lane steering,
//   and load extraction/extension. dmem_stage itself holds the FSM and registers.
// TESTING
//  SW addr 0x104 data 0xDEADBEEF, gnt first cycle -> mem_addr 0x104, be 1111, wdata 0xDEADBEEF.
//   The store does not pulse load_active.
//  LB addr 0x103, rdata 0x80FF0011 -> next_rd_value 0xFFFFFF80.
//   LBU at the same address -> 0x00000080.
//  LH addr 0x102, rdata 0x8001_1234, rd=7 -> next_rd=7, value 0xFFFF8001, load_active for 1 cycle.
//  gnt withheld 3 cycles -> mem_req and fields stable, req_ready=0 throughout.
//   A second req_valid is not accepted.
//  rst asserted in WAIT, then rvalid -> no load_active, state IDLE, req_ready=1.
//  LW addr 0x101 with MISALIGN_TRAP_EN -> no mem_req, exc_valid pulse, exc_addr 0x101.
//   Without the macro -> mem_addr 0x100, be 1111.

Source files
------------

// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared types and helpers for the data-memory stage.
//   state_t        : FSM states IDLE / REQ / WAIT
//   F3_*           : RV32 load/store funct3 encodings
//   size_t         : access size decoded from funct3 (undefined codes -> word)
//   f3_size        : funct3 -> size_t
//   byte_en        : byte enables for a size and address offset
//   is_misaligned  : natural-alignment check for a size and address offset
//   load_extend    : lane extraction and sign/zero extension of a read word
// The helpers operate on a fixed 4-lane (32-bit) word.
// -----------------------------------------------------------------------------
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_t;

  // Undefined encodings (011, 11x) fall into the word case.
  function automatic size_t f3_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: return SZ_B;
      F3_H, F3_HU: return SZ_H;
      default:     return SZ_W;
    endcase
  endfunction

  // Halfwords only look at a[1]; words always enable every lane.
  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] a);
    case (f3_size(f3))
      SZ_B:    return 4'b0001 << a;
      SZ_H:    return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3_size(f3))
      SZ_B:    return 1'b0;
      SZ_H:    return a[0];
      default: return a != 2'b00;
    endcase
  endfunction

  // f3[2] distinguishes the unsigned variants (BU/HU) from B/H.
  function automatic logic [31:0] load_extend(input logic [2:0]  f3,
                                               input logic [1:0]  a,
                                               input logic [31:0] w);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (f3_size(f3))
      SZ_B:    return f3[2] ? {24'd0, b} : 32'(b);
      SZ_H:    return f3[2] ? {16'd0, h} : 32'(h);
      default: return w;
    endcase
  endfunction

endpackage

// File: rtl/dmem_if.sv
// -----------------------------------------------------------------------------
// dmem_if
// Data-memory bus: req/gnt request phase followed by an rvalid read response.
//   mem_req    : request, held until mem_gnt
//   mem_we     : 1 = write
//   mem_addr   : word-aligned byte address
//   mem_be     : byte enables
//   mem_wdata  : lane-steered write data
//   mem_gnt    : request accepted this cycle
//   mem_rvalid : read data valid
//   mem_rdata  : read word
// master = the requesting stage, slave = the memory.
// -----------------------------------------------------------------------------
interface dmem_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [XLEN-1:0]   mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [XLEN-1:0]   mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/dmem_align.sv
// -----------------------------------------------------------------------------
// dmem_align
// Combinational byte-lane logic for the data-memory stage.
//   st_funct3, st_addr_lo, st_data : incoming store request (size, offset, data)
//   st_be, st_lanes                : byte enables and lane-replicated store data
//   ld_funct3, ld_addr_lo, ld_word : captured load size/offset and bus read word
//   ld_value                       : selected lane, sign- or zero-extended
// -----------------------------------------------------------------------------
module dmem_align
  import dmem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      st_funct3,
  input  logic [1:0]      st_addr_lo,
  input  logic [XLEN-1:0] st_data,
  output logic [3:0]      st_be,
  output logic [XLEN-1:0] st_lanes,
  input  logic [2:0]      ld_funct3,
  input  logic [1:0]      ld_addr_lo,
  input  logic [XLEN-1:0] ld_word,
  output logic [XLEN-1:0] ld_value
);

  // Replicating the data lets the memory pick it up from whichever lane
  // the byte enables select, so no shifter is needed.
  always_comb begin
    st_be    = byte_en(st_funct3, st_addr_lo);
    st_lanes = st_data;
    case (f3_size(st_funct3))
      SZ_B:    st_lanes = {4{st_data[7:0]}};
      SZ_H:    st_lanes = {2{st_data[15:0]}};
      default: st_lanes = st_data;
    endcase
  end

  assign ld_value = load_extend(ld_funct3, ld_addr_lo, ld_word);

endmodule

// File: rtl/dmem_stage.sv
// -----------------------------------------------------------------------------
// dmem_stage
// Data-memory stage between execute and writeback. Accepts one load/store,
// runs it on the data-memory bus and returns aligned/extended load data.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   req_valid       : execute presents a memory op
//   req_ready       : stage can accept (IDLE only)
//   req_load/store  : op kind (load wins when both are set)
//   req_funct3      : size/sign (B, H, W, BU, HU)
//   req_addr        : byte address
//   req_wdata       : LSB-justified store data
//   req_rd          : load destination register
//   mem             : dmem_if master (req/gnt/rvalid bus)
//   load_active     : one-cycle pulse, next_rd/next_rd_value hold a completed load
//   next_rd         : load destination
//   next_rd_value   : aligned, extended load value
//   exc_valid       : misaligned-access pulse
//   exc_addr        : faulting address
// Build option: define MISALIGN_TRAP_EN to trap misaligned H/W accesses
// (no bus request, exc_valid pulse). Without it exc_valid/exc_addr stay 0
// and misaligned accesses go out with forced alignment.
// -----------------------------------------------------------------------------
module dmem_stage
  import dmem_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int ADDR_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_load,
  input  logic                  req_store,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [XLEN-1:0]       req_wdata,
  input  logic [REG_ADDR_W-1:0] req_rd,
  dmem_if.master                mem,
  output logic                  load_active,
  output logic [REG_ADDR_W-1:0] next_rd,
  output logic [XLEN-1:0]       next_rd_value,
  output logic                  exc_valid,
  output logic [ADDR_W-1:0]     exc_addr
);

  state_t                state;
  logic [2:0]            funct3_q;
  logic [1:0]            addr_lo_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic                  mem_we_q;
  logic [ADDR_W-1:0]     mem_addr_q;
  logic [3:0]            mem_be_q;
  logic [XLEN-1:0]       mem_wdata_q;

  logic                  accept;
  logic                  trap;
  logic [3:0]            st_be;
  logic [XLEN-1:0]       st_lanes;
  logic [XLEN-1:0]       ld_value;

  dmem_align #(.XLEN(XLEN)) u_align (
    .st_funct3  (req_funct3),
    .st_addr_lo (req_addr[1:0]),
    .st_data    (req_wdata),
    .st_be      (st_be),
    .st_lanes   (st_lanes),
    .ld_funct3  (funct3_q),
    .ld_addr_lo (addr_lo_q),
    .ld_word    (mem.mem_rdata),
    .ld_value   (ld_value)
  );

  assign accept = req_valid & (req_load | req_store) & (state == IDLE);

`ifdef MISALIGN_TRAP_EN
  assign trap = is_misaligned(req_funct3, req_addr[1:0]);
`else
  assign trap = 1'b0;
`endif

  assign req_ready      = (state == IDLE);
  assign mem.mem_req    = (state == REQ);
  assign mem.mem_we     = mem_we_q;
  assign mem.mem_addr   = mem_addr_q;
  assign mem.mem_be     = mem_be_q;
  assign mem.mem_wdata  = mem_wdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      funct3_q      <= 3'd0;
      addr_lo_q     <= 2'd0;
      rd_q          <= '0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_be_q      <= 4'd0;
      mem_wdata_q   <= '0;
      load_active   <= 1'b0;
      next_rd       <= '0;
      next_rd_value <= '0;
      exc_valid     <= 1'b0;
      exc_addr      <= '0;
    end else begin
      load_active <= 1'b0;
      exc_valid   <= 1'b0;
      case (state)
        IDLE: begin
          if (accept && trap) begin
            exc_valid <= 1'b1;
            exc_addr  <= req_addr;
          end else if (accept) begin
            funct3_q    <= req_funct3;
            addr_lo_q   <= req_addr[1:0];
            rd_q        <= req_rd;
            mem_we_q    <= ~req_load;
            mem_addr_q  <= {req_addr[ADDR_W-1:2], 2'b00};
            mem_be_q    <= st_be;
            mem_wdata_q <= st_lanes;
            state       <= REQ;
          end
        end
        // An rvalid coinciding with gnt belongs to nobody and is dropped.
        REQ: begin
          if (mem.mem_gnt) begin
            state <= mem_we_q ? IDLE : WAIT;
          end
        end
        WAIT: begin
          if (mem.mem_rvalid) begin
            next_rd       <= rd_q;
            next_rd_value <= ld_value;
            load_active   <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_stage.sv
// -----------------------------------------------------------------------------
// tb_dmem_stage
// Directed testbench for dmem_stage. Inputs change and outputs are sampled
// on the falling clock edge; the memory side is driven directly through a
// dmem_if instance. Compile with MISALIGN_TRAP_EN to exercise the trap path.
// -----------------------------------------------------------------------------
module tb_dmem_stage;
  import dmem_pkg::*;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_load;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        load_active;
  logic [4:0]  next_rd;
  logic [31:0] next_rd_value;
  logic        exc_valid;
  logic [31:0] exc_addr;

  int n_checks;
  int n_errors;

  dmem_if #(.XLEN(32), .ADDR_W(32)) mem_bus ();

  dmem_stage #(.XLEN(32), .ADDR_W(32), .REG_ADDR_W(5)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_load      (req_load),
    .req_store     (req_store),
    .req_funct3    (req_funct3),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_rd        (req_rd),
    .mem           (mem_bus),
    .load_active   (load_active),
    .next_rd       (next_rd),
    .next_rd_value (next_rd_value),
    .exc_valid     (exc_valid),
    .exc_addr      (exc_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Load with gnt in the first REQ cycle and rvalid one cycle later.
  task automatic load_op(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] rdata, input logic [4:0] rd,
                         input logic [31:0] exp_addr, input logic [3:0] exp_be,
                         input logic [31:0] exp_val);
    @(negedge clk);
    req_valid = 1'b1; req_load = 1'b1; req_store = 1'b0;
    req_funct3 = f3; req_addr = addr; req_rd = rd; req_wdata = 32'h0;
    @(negedge clk);
    req_valid = 1'b0; req_load = 1'b0;
    chk_eq({tag, ".mem_req"}, mem_bus.mem_req, 1);
    chk_eq({tag, ".mem_we"}, mem_bus.mem_we, 0);
    chk_eq({tag, ".mem_addr"}, mem_bus.mem_addr, exp_addr);
    chk_eq({tag, ".mem_be"}, mem_bus.mem_be, exp_be);
    chk_eq({tag, ".req_ready"}, req_ready, 0);
    mem_bus.mem_gnt = 1'b1;
    @(negedge clk);
    mem_bus.mem_gnt = 1'b0;
    chk_eq({tag, ".wait_req"}, mem_bus.mem_req, 0);
    chk_eq({tag, ".early_la"}, load_active, 0);
    mem_bus.mem_rvalid = 1'b1; mem_bus.mem_rdata = rdata;
    @(negedge clk);
    mem_bus.mem_rvalid = 1'b0; mem_bus.mem_rdata = 32'h0;
    chk_eq({tag, ".load_active"}, load_active, 1);
    chk_eq({tag, ".next_rd"}, next_rd, rd);
    chk_eq({tag, ".value"}, next_rd_value, exp_val);
    chk_eq({tag, ".ready"}, req_ready, 1);
    @(negedge clk);
    chk_eq({tag, ".la_drop"}, load_active, 0);
    chk_eq({tag, ".hold"}, next_rd_value, exp_val);
  endtask

  // Store with gnt in the first REQ cycle; load result must be untouched.
  task automatic store_op(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] data, input logic [31:0] exp_addr,
                          input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                          input logic [31:0] held_val);
    @(negedge clk);
    req_valid = 1'b1; req_load = 1'b0; req_store = 1'b1;
    req_funct3 = f3; req_addr = addr; req_wdata = data; req_rd = 5'd0;
    @(negedge clk);
    req_valid = 1'b0; req_store = 1'b0;
    chk_eq({tag, ".mem_req"}, mem_bus.mem_req, 1);
    chk_eq({tag, ".mem_we"}, mem_bus.mem_we, 1);
    chk_eq({tag, ".mem_addr"}, mem_bus.mem_addr, exp_addr);
    chk_eq({tag, ".mem_be"}, mem_bus.mem_be, exp_be);
    chk_eq({tag, ".mem_wdata"}, mem_bus.mem_wdata, exp_wdata);
    mem_bus.mem_gnt = 1'b1;
    @(negedge clk);
    mem_bus.mem_gnt = 1'b0;
    chk_eq({tag, ".ready"}, req_ready, 1);
    chk_eq({tag, ".no_req"}, mem_bus.mem_req, 0);
    chk_eq({tag, ".no_la"}, load_active, 0);
    @(negedge clk);
    chk_eq({tag, ".no_la2"}, load_active, 0);
    chk_eq({tag, ".held"}, next_rd_value, held_val);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0;
    req_funct3 = 3'd0; req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd0;
    mem_bus.mem_gnt = 1'b0; mem_bus.mem_rvalid = 1'b0; mem_bus.mem_rdata = 32'h0;

    // Reset state
    repeat (2) @(negedge clk);
    chk_eq("rst.req_ready", req_ready, 1);
    chk_eq("rst.mem_req", mem_bus.mem_req, 0);
    chk_eq("rst.mem_be", mem_bus.mem_be, 0);
    chk_eq("rst.load_active", load_active, 0);
    chk_eq("rst.next_rd_value", next_rd_value, 0);
    chk_eq("rst.exc_valid", exc_valid, 0);
    rst = 1'b0;

    // Stores
    store_op("sw", F3_W, 32'h0000_0104, 32'hDEAD_BEEF, 32'h0000_0104, 4'b1111, 32'hDEAD_BEEF, 32'h0);
    store_op("sb", F3_B, 32'h0000_0102, 32'h0000_00A5, 32'h0000_0100, 4'b0100, 32'hA5A5_A5A5, 32'h0);
    store_op("sh", F3_H, 32'h0000_0106, 32'h1234_BEEF, 32'h0000_0104, 4'b1100, 32'hBEEF_BEEF, 32'h0);

    // Loads
    load_op("lb",  F3_B,   32'h0000_0103, 32'h80FF_0011, 5'd3,  32'h0000_0100, 4'b1000, 32'hFFFF_FF80);
    load_op("lbu", F3_BU,  32'h0000_0103, 32'h80FF_0011, 5'd4,  32'h0000_0100, 4'b1000, 32'h0000_0080);
    load_op("lh",  F3_H,   32'h0000_0102, 32'h8001_1234, 5'd7,  32'h0000_0100, 4'b1100, 32'hFFFF_8001);
    load_op("lhu", F3_HU,  32'h0000_0100, 32'h0000_F00D, 5'd9,  32'h0000_0100, 4'b0011, 32'h0000_F00D);
    load_op("lb1", F3_B,   32'h0000_0101, 32'h0000_7F00, 5'd10, 32'h0000_0100, 4'b0010, 32'h0000_007F);
    load_op("lw",  F3_W,   32'h0000_0108, 32'h1234_5678, 5'd11, 32'h0000_0108, 4'b1111, 32'h1234_5678);
    load_op("f3u", 3'b011, 32'h0000_010C, 32'hCAFE_BABE, 5'd12, 32'h0000_010C, 4'b1111, 32'hCAFE_BABE);

    // A store after a load leaves the load result alone
    store_op("sw2", F3_W, 32'h0000_0110, 32'h0101_0101, 32'h0000_0110, 4'b1111, 32'h0101_0101, 32'hCAFE_BABE);

    // gnt withheld 3 cycles while a second request is offered
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b1; req_load = 1'b0;
    req_funct3 = F3_W; req_addr = 32'h0000_0200; req_wdata = 32'h1122_3344;
    @(negedge clk);
    req_store = 1'b0; req_load = 1'b1; req_addr = 32'h0000_0300; req_wdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      chk_eq("stall.mem_req", mem_bus.mem_req, 1);
      chk_eq("stall.mem_addr", mem_bus.mem_addr, 32'h0000_0200);
      chk_eq("stall.mem_be", mem_bus.mem_be, 4'b1111);
      chk_eq("stall.mem_wdata", mem_bus.mem_wdata, 32'h1122_3344);
      chk_eq("stall.mem_we", mem_bus.mem_we, 1);
      chk_eq("stall.req_ready", req_ready, 0);
      @(negedge clk);
    end
    req_valid = 1'b0; req_load = 1'b0;
    chk_eq("stall.last_addr", mem_bus.mem_addr, 32'h0000_0200);
    mem_bus.mem_gnt = 1'b1;
    @(negedge clk);
    mem_bus.mem_gnt = 1'b0;
    chk_eq("stall.ready", req_ready, 1);
    chk_eq("stall.done_req", mem_bus.mem_req, 0);
    @(negedge clk);
    chk_eq("stall.no_second", mem_bus.mem_req, 0);

    // rvalid in the same cycle as gnt is ignored
    @(negedge clk);
    req_valid = 1'b1; req_load = 1'b1; req_funct3 = F3_W; req_addr = 32'h0000_0120; req_rd = 5'd13;
    @(negedge clk);
    req_valid = 1'b0; req_load = 1'b0;
    mem_bus.mem_gnt = 1'b1; mem_bus.mem_rvalid = 1'b1; mem_bus.mem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    mem_bus.mem_gnt = 1'b0; mem_bus.mem_rvalid = 1'b0;
    chk_eq("gntrv.no_la", load_active, 0);
    chk_eq("gntrv.waiting", req_ready, 0);
    mem_bus.mem_rvalid = 1'b1; mem_bus.mem_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    mem_bus.mem_rvalid = 1'b0;
    chk_eq("gntrv.la", load_active, 1);
    chk_eq("gntrv.value", next_rd_value, 32'h0BAD_F00D);
    chk_eq("gntrv.rd", next_rd, 13);

    // Reset while in REQ drops mem_req
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = F3_W; req_addr = 32'h0000_0130;
    @(negedge clk);
    req_valid = 1'b0; req_store = 1'b0;
    chk_eq("rstreq.mem_req", mem_bus.mem_req, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_eq("rstreq.dropped", mem_bus.mem_req, 0);
    chk_eq("rstreq.ready", req_ready, 1);

    // Reset while in WAIT, then a stray rvalid
    @(negedge clk);
    req_valid = 1'b1; req_load = 1'b1; req_funct3 = F3_W; req_addr = 32'h0000_0140; req_rd = 5'd14;
    @(negedge clk);
    req_valid = 1'b0; req_load = 1'b0;
    mem_bus.mem_gnt = 1'b1;
    @(negedge clk);
    mem_bus.mem_gnt = 1'b0;
    chk_eq("rstwait.in_wait", req_ready, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mem_bus.mem_rvalid = 1'b1; mem_bus.mem_rdata = 32'h5555_5555;
    @(negedge clk);
    mem_bus.mem_rvalid = 1'b0;
    chk_eq("rstwait.no_la", load_active, 0);
    chk_eq("rstwait.ready", req_ready, 1);
    chk_eq("rstwait.mem_req", mem_bus.mem_req, 0);
    chk_eq("rstwait.value", next_rd_value, 32'h0);

    // Misaligned word access
`ifdef MISALIGN_TRAP_EN
    @(negedge clk);
    req_valid = 1'b1; req_load = 1'b1; req_funct3 = F3_W; req_addr = 32'h0000_0101; req_rd = 5'd15;
    @(negedge clk);
    req_valid = 1'b0; req_load = 1'b0;
    chk_eq("trap.mem_req", mem_bus.mem_req, 0);
    chk_eq("trap.exc_valid", exc_valid, 1);
    chk_eq("trap.exc_addr", exc_addr, 32'h0000_0101);
    chk_eq("trap.ready", req_ready, 1);
    @(negedge clk);
    chk_eq("trap.exc_drop", exc_valid, 0);
    chk_eq("trap.still_idle", mem_bus.mem_req, 0);
`else
    load_op("lwmis", F3_W, 32'h0000_0101, 32'h0102_0304, 5'd15, 32'h0000_0100, 4'b1111, 32'h0102_0304);
    chk_eq("lwmis.no_exc", exc_valid, 0);
    load_op("lhmis", F3_H, 32'h0000_0101, 32'hAAAA_8123, 5'd16, 32'h0000_0100, 4'b0011, 32'hFFFF_8123);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
